// File: rtl/vga_frame_capture.sv
// vga_frame_capture: single-shot VGA grab, 2x2 downsampled into the frame buffer port A. Define FRAME_CHECK_EN for line/frame timing checks.
// Latency: the pixel sampled at a clock edge appears on wea/addra/dina directly after that edge (one register stage).
// Backpressure: none; the frame buffer must accept one write every other pixel clock.
module vga_frame_capture #(
    parameter int HD       = 640,
    parameter int VD       = 480,
    parameter int H_OFFSET = 144,
    parameter int V_OFFSET = 35
`ifdef FRAME_CHECK_EN
    ,
    parameter int HT       = 800,
    parameter int VT       = 525
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] pixel,
    output logic        wea,
    output logic [16:0] addra,
    output logic [11:0] dina,
    output logic        busy,
    output logic        done,
    output logic        sync_err
);

    localparam logic [9:0]  H_LO      = 10'(H_OFFSET);
    localparam logic [9:0]  H_HI      = 10'(H_OFFSET + HD - 1);
    localparam logic [9:0]  V_LO      = 10'(V_OFFSET);
    localparam logic [9:0]  V_HI      = 10'(V_OFFSET + VD - 1);
    localparam logic [16:0] ROW_PITCH = 17'(HD / 2);
    localparam logic [16:0] LAST_ADDR = 17'((VD / 2) * (HD / 2) - 1);
    localparam logic [9:0]  CNT_MAX   = 10'h3FF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic        hs_q, vs_q;
    logic        hs_fall, vs_fall;
    logic [9:0]  hc_q, hc_d;
    logic [9:0]  lc_q, lc_d;
    logic [9:0]  col, row;
    logic        active;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic        wea_q;
    logic [16:0] addra_q;
    logic [11:0] dina_q;
    logic        abort;

    assign hs_fall = hs_q & ~hsync;
    assign vs_fall = vs_q & ~vsync;

    // Position is judged on the post-update counter so the first low hsync sample is hc=0.
    always_comb begin
        hc_d = (hc_q == CNT_MAX) ? hc_q : hc_q + 10'd1;
        if (hs_fall) begin
            hc_d = 10'd0;
        end
        lc_d = lc_q;
        if (vs_fall) begin
            lc_d = 10'd0;
        end else if (hs_fall && lc_q != CNT_MAX) begin
            lc_d = lc_q + 10'd1;
        end
    end

    assign col     = hc_d - H_LO;
    assign row     = lc_d - V_LO;
    assign active  = (hc_d >= H_LO) && (hc_d <= H_HI) && (lc_d >= V_LO) && (lc_d <= V_HI);
    assign wr_en   = active && !col[0] && !row[0] && (state_q == S_CAPTURE);
    assign wr_addr = 17'(row[9:1]) * ROW_PITCH + 17'(col[9:1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            hc_q    <= 10'd0;
            lc_q    <= 10'd0;
            wea_q   <= 1'b0;
            addra_q <= 17'd0;
            dina_q  <= 12'd0;
        end else begin
            hs_q  <= hsync;
            vs_q  <= vsync;
            hc_q  <= hc_d;
            lc_q  <= lc_d;
            wea_q <= wr_en;
            if (wr_en) begin
                addra_q <= wr_addr;
                dina_q  <= pixel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The final write is already on the port when CAPTURE exits, so done lands one cycle later.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (vs_fall) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (vs_fall) begin
                    state_d = S_IDLE;
                end else if (wea_q && addra_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign abort = (state_q == S_CAPTURE) && vs_fall;
    assign wea   = wea_q;
    assign addra = addra_q;
    assign dina  = dina_q;
    assign busy  = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    assign done  = (state_q == S_DONE);

`ifdef FRAME_CHECK_EN
    localparam logic [9:0] LINE_LAST = 10'(HT - 1);
    localparam logic [9:0] FRAME_LAST = 10'(VT - 1);

    logic line_seen_q, frame_seen_q, err_q;

    // hc/lc still hold the closing count of the previous line/frame on the falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_seen_q  <= 1'b0;
            frame_seen_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (hs_fall) begin
                line_seen_q <= 1'b1;
                if (line_seen_q && hc_q != LINE_LAST) begin
                    err_q <= 1'b1;
                end
            end
            if (vs_fall) begin
                frame_seen_q <= 1'b1;
                if (frame_seen_q && lc_q != FRAME_LAST) begin
                    err_q <= 1'b1;
                end
            end
            if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign sync_err = err_q;
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign sync_err     = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a reduced 48x24 raster (32x16 active) so whole frames stay short.
module tb_vga_frame_capture;

    localparam int HD   = 32;
    localparam int VD   = 16;
    localparam int HOFF = 10;
    localparam int VOFF = 4;
    localparam int HT   = 48;
    localparam int VT   = 24;
    localparam int HSW  = 4;
    localparam int VSW  = 2;
    localparam logic [16:0] LAST = 17'((VD / 2) * (HD / 2) - 1);
`ifdef FRAME_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [11:0] pixel = 12'd0;
    logic        wea, busy, done, sync_err;
    logic [16:0] addra;
    logic [11:0] dina;

    vga_frame_capture #(
        .HD(HD), .VD(VD), .H_OFFSET(HOFF), .V_OFFSET(VOFF)
`ifdef FRAME_CHECK_EN
        , .HT(HT), .VT(VT)
`endif
    ) dut (
        .clk(clk), .rst(rst), .start(start), .hsync(hsync), .vsync(vsync),
        .pixel(pixel), .wea(wea), .addra(addra), .dina(dina),
        .busy(busy), .done(done), .sync_err(sync_err)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic [16:0] addr;
        logic [11:0] data;
    } wr_t;

    typedef struct {
        int start_frame;
        int start_line;
        int restart_line;
        int abort_line;
        int short_line;
        int nframes;
        int exp_wr;
        int exp_done;
        bit exp_err;
    } scen_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  n_wr = 0;
    int  n_done = 0;
    int  cyc = 0;
    int  e0 = 0;
    bit  prev_last = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_cycle(input logic hs, input logic vs, input logic [11:0] px, input logic st);
        hsync = hs;
        vsync = vs;
        pixel = px;
        start = st;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Scoreboard side: every strobe must match the next expected write in order.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst) begin
            if (wea) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addra %0d dina %0h, expected no write", addra, dina);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(addra), 32'(e.addr));
                    check("wr_data", 32'(dina), 32'(e.data));
                end
                // The hsync edge's own cycle counts as cycle 1, so the write lands in cycle HOFF+1.
                if (addra == 17'd0) check("first_write_latency", 32'(cyc - e0), 32'(HOFF));
            end
            if (done) begin
                n_done++;
                check("done_follows_last_write", 32'(prev_last), 32'd1);
                check("busy_low_with_done", 32'(busy), 32'd0);
            end
            prev_last = wea && (addra == LAST);
        end else begin
            prev_last = 1'b0;
        end
    end

    task automatic drive_frame(input int f, input scen_t s);
        bit cap;
        int len, r, c;
        bit act, st, arm_pt;
        logic [11:0] px;
        cap = (s.start_frame >= 0) && (f == s.start_frame + 1);
        for (int ln = 0; ln < VT; ln++) begin
            if (cap && s.abort_line >= 0 && ln == s.abort_line) return;
            len = (f == 1 && s.short_line >= 0 && ln == s.short_line) ? HT - 1 : HT;
            for (int x = 0; x < len; x++) begin
                r = ln - VOFF;
                c = x - HOFF;
                act = (r >= 0) && (r < VD) && (c >= 0) && (c < HD);
                px = act ? {4'(r), 8'(c)} : 12'hABC;
                arm_pt = (f == s.start_frame) && (ln == s.start_line) && (x == 20);
                st = arm_pt || (cap && s.restart_line >= 0 && ln == s.restart_line && x == 20);
                if (act && cap && (r % 2 == 0) && (c % 2 == 0))
                    exp_q.push_back({17'((r / 2) * (HD / 2) + c / 2), px});
                drive_cycle((x < HSW) ? 1'b0 : 1'b1, (ln < VSW) ? 1'b0 : 1'b1, px, st);
                if (cap && ln == VOFF && x == 0) e0 = cyc;
                if (arm_pt) check("busy_after_start", 32'(busy), 32'd1);
                if (f == 1 && s.short_line >= 0) begin
                    if (ln == s.short_line && x == len - 1)
                        check("err_before_short_close", 32'(sync_err), 32'd0);
                    if (ln == s.short_line + 1 && x == 0)
                        check("err_at_short_close", 32'(sync_err), 32'(FC));
                end
            end
        end
    endtask

    task automatic reset_and_check();
        rst = 1'b0;
        repeat (3) drive_cycle(1'b1, 1'b1, 12'd0, 1'b0);
        rst = 1'b1;
        drive_cycle(1'b1, 1'b1, 12'd0, 1'b0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        check("rst_wea", 32'(wea), 32'd0);
        check("rst_addra", 32'(addra), 32'd0);
        exp_q.delete();
        n_wr = 0;
        n_done = 0;
    endtask

    scen_t sc[4];

    initial begin
        // start frame, start line, restart line, abort line, short line, frames, writes, dones, sync_err
        sc[0] = '{0, 10, -1, -1, -1, 4, 128, 1, 1'b0};
        sc[1] = '{0, 10,  8, -1, -1, 2, 128, 1, 1'b0};
        sc[2] = '{0, 10, -1, 10, -1, 3,  48, 0, FC};
        sc[3] = '{-1, 0, -1, -1,  5, 3,   0, 0, FC};

        // Syncs held low through and after reset, with no edges afterwards.
        rst = 1'b0;
        repeat (3) drive_cycle(1'b0, 1'b0, 12'd0, 1'b0);
        rst = 1'b1;
        repeat (40) drive_cycle(1'b0, 1'b0, 12'h5A5, 1'b0);
        check("low_wea", 32'(wea), 32'd0);
        check("low_addra", 32'(addra), 32'd0);
        check("low_dina", 32'(dina), 32'd0);
        check("low_busy", 32'(busy), 32'd0);
        check("low_done", 32'(done), 32'd0);
        check("low_sync_err", 32'(sync_err), 32'd0);
        drive_cycle(1'b0, 1'b0, 12'd0, 1'b1);
        check("low_armed_busy", 32'(busy), 32'd1);
        repeat (40) drive_cycle(1'b0, 1'b0, 12'h5A5, 1'b0);
        check("low_no_writes", 32'(n_wr), 32'd0);
        reset_and_check();

        for (int i = 0; i < 4; i++) begin
            for (int f = 0; f < sc[i].nframes; f++) drive_frame(f, sc[i]);
            repeat (4) drive_cycle(1'b1, 1'b1, 12'd0, 1'b0);
            check("write_count", 32'(n_wr), 32'(sc[i].exp_wr));
            check("done_count", 32'(n_done), 32'(sc[i].exp_done));
            check("queue_drained", 32'(exp_q.size()), 32'd0);
            check("busy_after_run", 32'(busy), 32'd0);
            check("sync_err_after_run", 32'(sync_err), 32'(sc[i].exp_err));
            reset_and_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_frame_capture.md
# vga_frame_capture

Receive side of the 640x480 VGA interface: samples an incoming hsync/vsync/12-bit pixel stream in the pixel clock domain, recovers line/pixel position from the sync edges, and writes one 2x2-downsampled frame into the 320x240 frame buffer (block RAM port A). The frame buffer is then read by the display-side address generator. Capture is single-shot per `start` pulse.

## Interface
- `HD`, 640, active pixels per line
- `VD`, 480, active lines per frame
- `H_OFFSET`, 144, cycles from first low hsync sample to first active pixel (HS+HB)
- `V_OFFSET`, 35, line-count value during active line 0 (VS+VB)
- `HT`, 800, total cycles per line (frame check only)
- `VT`, 525, total lines per frame (frame check only)
- `clk`  in  1  pixel clock, 25 MHz; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse, arms one frame capture
- `hsync`  in  1  active-low horizontal sync
- `vsync`  in  1  active-low vertical sync
- `pixel`  in  12  {R,G,B} sample, valid only in active region
- `wea`  out  1  frame-buffer write strobe
- `addra`  out  17  frame-buffer address, 0..76799
- `dina`  out  12  frame-buffer write data
- `busy`  out  1  high in ARMED or CAPTURE
- `done`  out  1  one-cycle pulse on frame completion
- `sync_err`  out  1  sticky frame-timing error (only with FRAME_CHECK_EN)

## Operation
- Edge detect: `hsync`/`vsync` registered once; falling edge = current sample 0, previous sample 1.
- Pixel counter `hc` (10 bit): on hsync falling edge loads 0; otherwise increments, saturating at 1023.
- Line counter `lc` (10 bit): on vsync falling edge loads 0; else on hsync falling edge increments, saturating at 1023. If both edges occur in the same cycle, vsync wins (`lc`=0).
- Active sample: `hc` in [H_OFFSET, H_OFFSET+HD-1] and `lc` in [V_OFFSET, V_OFFSET+VD-1]; col = `hc`-H_OFFSET, row = `lc`-V_OFFSET.
- Write: active sample with col and row both even → `addra` = (row>>1)*320 + (col>>1), `dina` = `pixel`, `wea`=1; odd col or row → `wea`=0.
- FSM states:
  - IDLE: `start` → ARMED.
  - ARMED: vsync falling edge → CAPTURE. A `start` arriving mid-frame always waits for the next vsync.
  - CAPTURE: writes enabled. After the write of row VD-2, col HD-2 (`addra`=76799) → DONE. A vsync falling edge before that → IDLE (abort, no `done`), and `sync_err` is set if FRAME_CHECK_EN.
  - DONE: one cycle, `done`=1 → IDLE.
- `start` outside IDLE is ignored.
- Writes occur only in CAPTURE; exactly 76800 writes per completed capture, addresses strictly increasing.
- Reset (any state, mid-frame included): FSM → IDLE, `hc`=`lc`=0, `wea`=0, `addra`=0, `dina`=0, `busy`=0, `done`=0, `sync_err`=0. Edge-detect registers reset to 1 (idle-high), so an input held low through reset produces no false edge.

## Timing
- Sample to write latency: `pixel` sampled at edge t → `wea`/`addra`/`dina` valid in cycle t+1 (registered outputs).
- `busy` rises the cycle after `start` is sampled.
- `done` asserts the cycle after the final write strobe; `busy` drops in the same cycle.
- Write strobes: one every 2 cycles within an even active line; none on odd lines or blanking.
- First write of a capture occurs H_OFFSET+1 cycles after the hsync falling edge that takes `lc` to V_OFFSET.

## Configuration
- `FRAME_CHECK_EN` defined: on each hsync falling edge, checks that the preceding line was exactly HT cycles; on each vsync falling edge, checks that the preceding frame was exactly VT lines. The first line and first frame after reset are exempt. Any mismatch, or an abort, sets `sync_err`, which clears only on reset. Capture behaviour is unchanged.
- Not defined: no check logic; `sync_err` is tied to 0.

## Test plan
- Reset with `hsync`/`vsync` low, release, no sync activity → all outputs 0, no `wea`, state IDLE.
- Standard 800x525 stream with pixel = {row[3:0], col[7:0]}, `start` pulse mid-frame → no writes until next vsync. Then 76800 writes: first `addra`=0 `dina`=12'h000, `addra`=1 `dina`=12'h002, last `addra`=76799. `done` fires once.
- After `done`, continue the stream for 2 frames without `start` → zero writes, `busy`=0.
- `start` pulsed again during CAPTURE → ignored: exactly 76800 writes and one `done`.
- Inject vsync falling edge at row 100 during CAPTURE → return to IDLE, no `done`. `sync_err`=1 with FRAME_CHECK_EN, 0 without.
- FRAME_CHECK_EN: one line of 799 cycles in an otherwise legal stream → `sync_err` rises at that line's closing hsync edge and stays high until `rst` is asserted.
